// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_operandA0,
  input  logic [31:0] req_operandA1,
  input  logic [31:0] req_operandB0,
  input  logic [31:0] req_operandB1,
  input  logic [5:0]  req_opcode0,
  input  logic [5:0]  req_opcode1,
  input  logic [5:0]  req_funct0,
  input  logic [5:0]  req_funct1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_carryout,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carryout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [5:0]  alu_op_q, alu_op_d, alu_fn_q, alu_fn_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic        rsp_z_q, rsp_z_d, rsp_v_q, rsp_v_d, rsp_c_q, rsp_c_d;
  logic        g;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_fn_d  = alu_fn_q;
    rsp_res_d = rsp_res_q;
    rsp_z_d   = rsp_z_q;
    rsp_v_d   = rsp_v_q;
    rsp_c_d   = rsp_c_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    // On a tie the port that was not served last wins.
    g = (req_valid == 2'b11) ? ~last_q : req_valid[1];

    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = g ? 2'b10 : 2'b01;
          state_d   = S_EXEC;
          last_d    = g;
          gnt_d     = g;
          cnt_d     = CNT_INIT;
          alu_a_d   = g ? req_operandA1 : req_operandA0;
          alu_b_d   = g ? req_operandB1 : req_operandB0;
          alu_op_d  = g ? req_opcode1 : req_opcode0;
          alu_fn_d  = g ? req_funct1 : req_funct0;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_res_d = alu_res;
          rsp_z_d   = alu_zero;
          rsp_v_d   = alu_overflow;
          rsp_c_d   = alu_carryout;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset cycle neither accepts a request nor delivers a response.
    if (reset) begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= 4'd0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_fn_q  <= '0;
      rsp_res_q <= '0;
      rsp_z_q   <= 1'b0;
      rsp_v_q   <= 1'b0;
      rsp_c_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_fn_q  <= alu_fn_d;
      rsp_res_q <= rsp_res_d;
      rsp_z_q   <= rsp_z_d;
      rsp_v_q   <= rsp_v_d;
      rsp_c_q   <= rsp_c_d;
    end
  end

  assign alu_operandA = alu_a_q;
  assign alu_operandB = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign alu_funct    = alu_fn_q;
  assign rsp_res      = rsp_res_q;
  assign rsp_zero     = rsp_z_q;
  assign rsp_overflow = rsp_v_q;
  assign rsp_carryout = rsp_c_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int SETTLE = 2;
  localparam logic [5:0] OP_R = 6'h00, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [5:0]  fn;
  } pay_t;

  typedef struct packed {
    logic        c;
    logic        v;
    logic        z;
    logic [31:0] r;
  } alu_out_t;

  typedef struct packed {
    logic        pre_rst;
    logic [1:0]  valid;
    pay_t        p0;
    pay_t        p1;
    logic        port;
    logic [31:0] res;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  pay_t        pl0, pl1;
  logic [31:0] rsp_res, alu_operandA, alu_operandB, alu_res;
  logic        rsp_zero, rsp_overflow, rsp_carryout;
  logic [5:0]  alu_opcode, alu_funct;
  logic        alu_zero, alu_overflow, alu_carryout, busy;
  pay_t        alu_in;
  alu_out_t    alu_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operandA0(pl0.a), .req_operandA1(pl1.a),
    .req_operandB0(pl0.b), .req_operandB1(pl1.b),
    .req_opcode0(pl0.op), .req_opcode1(pl1.op),
    .req_funct0(pl0.fn), .req_funct1(pl1.fn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_carryout(rsp_carryout),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_opcode(alu_opcode), .alu_funct(alu_funct),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
    .busy(busy)
  );

  // Behavioural ALU: subtraction is A + ~B + 1, carry is bit 32 of that sum.
  function automatic alu_out_t alu_fn(input pay_t p);
    alu_out_t o;
    logic        sub;
    logic [31:0] bb;
    logic [32:0] s;
    sub = (p.op == OP_BEQ) || (p.op == OP_R && p.fn == F_SUB);
    bb  = sub ? ~p.b : p.b;
    s   = {1'b0, p.a} + {1'b0, bb} + {32'd0, sub};
    o.r = s[31:0];
    o.c = s[32];
    o.v = (p.a[31] == bb[31]) && (o.r[31] != p.a[31]);
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  assign alu_in = {alu_operandA, alu_operandB, alu_opcode, alu_funct};
  assign alu_o  = alu_fn(alu_in);
  assign alu_res = alu_o.r;
  assign alu_zero = alu_o.z;
  assign alu_overflow = alu_o.v;
  assign alu_carryout = alu_o.c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic pay_t rand_pay();
    pay_t p;
    int k;
    k = $urandom_range(0, 3);
    p.a = $urandom;
    p.b = ($urandom_range(0, 3) == 0) ? p.a : $urandom;
    p.fn = 6'($urandom);
    case (k)
      0: begin p.op = OP_R; p.fn = F_ADD; end
      1: begin p.op = OP_R; p.fn = F_SUB; end
      2: p.op = OP_ADDI;
      default: p.op = OP_BEQ;
    endcase
    return p;
  endfunction

  task automatic run_vec(input int idx, input vec_t tv);
    int n;
    logic [1:0] oh;
    oh = tv.port ? 2'b10 : 2'b01;
    pl0 = tv.p0;
    pl1 = tv.p1;
    req_valid = tv.valid;
    rsp_ready = ~oh;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
    check($sformatf("v%0d_grant", idx), 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    req_valid = req_valid & ~oh;
    n = 1;
    while (rsp_valid == 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
    check($sformatf("v%0d_latency", idx), 64'(n), 64'(SETTLE + 1));
    check($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid), 64'(oh));
    check($sformatf("v%0d_res", idx), 64'(rsp_res), 64'(tv.res));
    check($sformatf("v%0d_flags_zvc", idx), 64'({rsp_zero, rsp_overflow, rsp_carryout}),
          64'({tv.z, tv.v, tv.c}));
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check($sformatf("v%0d_drop", idx), 64'(rsp_valid), 64'd0);
    check($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
  endtask

  vec_t       vecs[5];
  int         ng, n;
  logic       gport[4];
  int         gcyc[4];
  logic [1:0] exp_rr, exp_rv;
  logic       gsel, m_busy, m_port, m_last;
  int         m_hs;
  alu_out_t   m_exp;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 2'b01, '{32'd7000, 32'd14000, OP_ADDI, 6'd0}, '0,
                1'b0, 32'd21000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'b11, '{32'h80000004, 32'h80000004, OP_R, F_ADD},
                '{32'd0, 32'd637483644, OP_R, F_SUB},
                1'b0, 32'd8, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 2'b10, '0, '{32'd0, 32'd637483644, OP_R, F_SUB},
                1'b1, 32'd3657483652, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'b10, '0, '{32'd637483644, 32'd637483644, OP_BEQ, 6'd0},
                1'b1, 32'd0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 2'b01, '{32'd637483644, 32'd637483644, OP_BEQ, 6'd0}, '0,
                1'b0, 32'd0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    pl0 = '0;
    pl1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rsp", 64'({rsp_zero, rsp_overflow, rsp_carryout, rsp_res}), 64'd0);
    check("reset_alu_ab", {alu_operandA, alu_operandB}, 64'd0);
    check("reset_alu_opfn", 64'({alu_opcode, alu_funct}), 64'd0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].pre_rst) reset_dut();
      run_vec(i, vecs[i]);
    end

    // Fairness: both ports always valid, response accepted at once.
    reset_dut();
    pl0 = '{32'd1, 32'd2, OP_R, F_ADD};
    pl1 = '{32'd5, 32'd3, OP_R, F_SUB};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        gport[ng] = req_ready[1];
        gcyc[ng] = c;
        ng++;
      end
      @(posedge clk); #1;
    end
    check("fair_grants", 64'(ng), 64'd4);
    for (int k = 0; k < ng; k++) begin
      check($sformatf("fair_order%0d", k), 64'(gport[k]), 64'(k % 2));
      if (k > 0) check($sformatf("fair_span%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'(SETTLE + 2));
    end
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;

    // Backpressure on port 0 while port 1 waits.
    reset_dut();
    pl0 = '{32'd100, 32'd23, OP_ADDI, 6'd5};
    pl1 = '{32'd9, 32'd4, OP_R, F_ADD};
    req_valid = 2'b01;
    #1;
    check("bp_grant0", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    n = 0;
    while (rsp_valid == 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_rsp_valid%0d", k), 64'(rsp_valid), 64'b01);
      check($sformatf("bp_res%0d", k), 64'(rsp_res), 64'd123);
      check($sformatf("bp_req_ready%0d", k), 64'(req_ready), 64'd0);
      check($sformatf("bp_busy%0d", k), 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    check("bp_rsp_drop", 64'(rsp_valid), 64'd0);
    check("bp_grant1", 64'(req_ready), 64'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (6) @(posedge clk);
    #1;

    // Reset in the first EXEC cycle after serving port 0.
    reset_dut();
    pl0 = '{32'd77, 32'd11, OP_ADDI, 6'h11};
    req_valid = 2'b01;
    #1;
    check("rst_grant0", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    reset = 1'b1;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_ab", {alu_operandA, alu_operandB}, 64'd0);
    check("rst_alu_opfn", 64'({alu_opcode, alu_funct}), 64'd0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid != 2'b00) n++;
      @(posedge clk); #1;
    end
    check("rst_no_response", 64'(n), 64'd0);
    pl1 = '{32'd3, 32'd4, OP_R, F_ADD};
    req_valid = 2'b11;
    #1;
    check("rst_tie_port0", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;

    // Randomised traffic against a transaction-level model.
    reset_dut();
    m_busy = 1'b0;
    m_port = 1'b0;
    m_last = 1'b1;
    m_hs = 0;
    m_exp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!req_valid[0] && $urandom_range(0, 2) == 0) begin pl0 = rand_pay(); req_valid[0] = 1'b1; end
      if (!req_valid[1] && $urandom_range(0, 2) == 0) begin pl1 = rand_pay(); req_valid[1] = 1'b1; end
      rsp_ready = 2'($urandom);
      #1;
      exp_rr = 2'b00;
      gsel = 1'b0;
      if (!m_busy && req_valid != 2'b00) begin
        gsel = (req_valid == 2'b11) ? !m_last : req_valid[1];
        exp_rr = gsel ? 2'b10 : 2'b01;
      end
      exp_rv = (m_busy && (cyc - m_hs) >= SETTLE + 1) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_req_ready", 64'(req_ready), 64'(exp_rr));
      check("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("rnd_busy", 64'(busy), 64'(m_busy));
      if (exp_rv != 2'b00) begin
        check("rnd_rsp", 64'({rsp_carryout, rsp_overflow, rsp_zero, rsp_res}), 64'(m_exp));
        if (rsp_ready[m_port]) m_busy = 1'b0;
      end
      if (exp_rr != 2'b00) begin
        m_busy = 1'b1;
        m_port = gsel;
        m_last = gsel;
        m_hs = cyc;
        m_exp = gsel ? alu_fn(pl1) : alu_fn(pl0);
      end
      @(posedge clk); #1;
      if (exp_rr != 2'b00) req_valid[gsel] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
